// File: rtl/adc_pkg.sv
// -----------------------------------------------------------------------------
// adc_pkg
// Shared definitions for the MCP3202 acquisition path: sequencer state
// encodings, channel constants, MCP3202 command bits (also used by the SPI
// conversion engine), default sample timing, and the round-robin channel
// picker used by the sequencer.
// No ports (package).
// -----------------------------------------------------------------------------
package adc_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TICK = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_STORE     = 3'd4
    } seq_state_e;

    // Channel identifiers; the value doubles as the MCP3202 ODD bit
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // MCP3202 command bits: start bit, single-ended mode, MSB-first output
    localparam logic MCP_START = 1'b1;
    localparam logic MCP_SGL   = 1'b1;
    localparam logic MCP_MSBF  = 1'b1;

    // 50 kHz sample rate from a 125 MHz clock
    localparam int unsigned DEFAULT_SAMPLE_DIV = 2500;
    localparam int unsigned DEFAULT_TIMEOUT    = 2400;

    // Result of a channel pick: valid is low when no channel is enabled
    typedef struct packed {
        logic valid;
        logic ch;
    } ch_pick_t;

    // Round-robin pick under a channel mask. With both channels enabled the
    // channel opposite the last one served wins.
    function automatic ch_pick_t pick_channel(input logic [1:0] mask,
                                              input logic       last_ch);
        ch_pick_t p;
        p.valid = 1'b1;
        p.ch    = CH0;
        case (mask)
            2'b00:   p.valid = 1'b0;
            2'b01:   p.ch    = CH0;
            2'b10:   p.ch    = CH1;
            default: p.ch    = ~last_ch;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// -----------------------------------------------------------------------------
// sample_tick_gen
// Enable-gated modulo-DIV counter producing a one-cycle tick when the count
// reaches DIV-1. The count is held at 0 while disabled, so the first tick
// arrives DIV cycles after enable rises. Reusable by the DAC update path.
// Ports:
//   clk       in  system clock
//   rst_n     in  synchronous active-low reset
//   enable_i  in  run the counter; low clears it
//   tick_o    out one-cycle tick at count = DIV-1
// -----------------------------------------------------------------------------
module sample_tick_gen
    import adc_pkg::*;
#(
    parameter int unsigned DIV = DEFAULT_SAMPLE_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    output logic tick_o
);

    localparam int unsigned   CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] COUNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: wrap at DIV-1, collapse to zero whenever disabled
    always_comb begin
        count_d = count_q;
        if (!enable_i) begin
            count_d = '0;
        end else if (count_q == COUNT_MAX) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = enable_i && (count_q == COUNT_MAX);

endmodule

// File: rtl/adc_conversion_sequencer.sv
// -----------------------------------------------------------------------------
// adc_conversion_sequencer
// Issues one MCP3202 conversion per sample tick, alternating channels
// round-robin under a runtime mask, captures each 12-bit result into a
// per-channel holding register and flags overruns and engine timeouts.
// All outputs are registered.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_enable          run the sequencer; low stops new starts
//   i_ch_mask[1:0]    bit0 = CH0 enabled, bit1 = CH1 enabled
//   o_cnv_start       one-cycle start pulse to the conversion engine
//   o_cnv_odd         ODD bit (channel) of the current conversion
//   i_cnv_busy        engine busy; starts wait while high
//   i_cnv_done        one-cycle done pulse, i_cnv_data valid with it
//   i_cnv_data[11:0]  conversion result
//   o_ch0_data, o_ch1_data  last result per channel
//   o_data_valid, o_data_ch one-cycle new-result pulse and its channel
//   o_overrun         tick arrived while a conversion was in progress
//   o_timeout         engine did not answer within TIMEOUT cycles
// -----------------------------------------------------------------------------
module adc_conversion_sequencer
    import adc_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_enable,
    input  logic [1:0]  i_ch_mask,
    output logic        o_cnv_start,
    output logic        o_cnv_odd,
    input  logic        i_cnv_busy,
    input  logic        i_cnv_done,
    input  logic [11:0] i_cnv_data,
    output logic [11:0] o_ch0_data,
    output logic [11:0] o_ch1_data,
    output logic        o_data_valid,
    output logic        o_data_ch,
    output logic        o_overrun,
    output logic        o_timeout
);

    localparam int unsigned   TW         = $clog2(TIMEOUT + 1);
    // Timeout decision is made one cycle early so the registered pulse lands
    // on the cycle where the count reaches TIMEOUT.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    seq_state_e    state_q, state_d;
    logic          sel_ch_q, sel_ch_d;
    logic          last_ch_q, last_ch_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [11:0]   ch0_q, ch0_d;
    logic [11:0]   ch1_q, ch1_d;
    logic          data_ch_q, data_ch_d;
    logic          start_q, start_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic          timeout_q, timeout_d;
    logic          tick;
    ch_pick_t      pick;

    sample_tick_gen #(
        .DIV(SAMPLE_DIV)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable_i(i_enable),
        .tick_o  (tick)
    );

    // Next-state and registered-output decisions. Results and the STORE-cycle
    // pulses are computed on the done cycle so they appear one cycle after
    // done. last_ch advances on timeout too, so a hung channel cannot starve
    // the other one.
    always_comb begin
        state_d   = state_q;
        sel_ch_d  = sel_ch_q;
        last_ch_d = last_ch_q;
        timer_d   = '0;
        ch0_d     = ch0_q;
        ch1_d     = ch1_q;
        data_ch_d = data_ch_q;
        start_d   = 1'b0;
        valid_d   = 1'b0;
        overrun_d = 1'b0;
        timeout_d = 1'b0;
        pick      = pick_channel(i_ch_mask, last_ch_q);

        unique case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d = ST_WAIT_TICK;
                end
            end
            ST_WAIT_TICK: begin
                if (!i_enable) begin
                    state_d = ST_IDLE;
                end else if (tick && pick.valid) begin
                    sel_ch_d = pick.ch;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                overrun_d = tick;
                if (!i_enable) begin
                    state_d = ST_IDLE;
                end else if (!i_cnv_busy) begin
                    start_d = 1'b1;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                overrun_d = tick;
                if (i_cnv_done) begin
                    if (sel_ch_q == CH0) begin
                        ch0_d = i_cnv_data;
                    end else begin
                        ch1_d = i_cnv_data;
                    end
                    valid_d   = 1'b1;
                    data_ch_d = sel_ch_q;
                    last_ch_d = sel_ch_q;
                    state_d   = ST_STORE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    last_ch_d = sel_ch_q;
                    state_d   = i_enable ? ST_WAIT_TICK : ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_STORE: begin
                overrun_d = tick;
                state_d   = i_enable ? ST_WAIT_TICK : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; last_ch resets to CH1 so CH0 is served first
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_ch_q  <= CH0;
            last_ch_q <= CH1;
            timer_q   <= '0;
            ch0_q     <= '0;
            ch1_q     <= '0;
            data_ch_q <= 1'b0;
            start_q   <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_ch_q  <= sel_ch_d;
            last_ch_q <= last_ch_d;
            timer_q   <= timer_d;
            ch0_q     <= ch0_d;
            ch1_q     <= ch1_d;
            data_ch_q <= data_ch_d;
            start_q   <= start_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_cnv_start  = start_q;
    assign o_cnv_odd    = sel_ch_q;
    assign o_ch0_data   = ch0_q;
    assign o_ch1_data   = ch1_q;
    assign o_data_valid = valid_q;
    assign o_data_ch    = data_ch_q;
    assign o_overrun    = overrun_q;
    assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_adc_conversion_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc_conversion_sequencer
// Directed bench for adc_conversion_sequencer with SAMPLE_DIV=20, TIMEOUT=19
// and a behavioural MCP3202 engine whose done latency is set per step
// (0 = engine never answers).
// -----------------------------------------------------------------------------
module tb_adc_conversion_sequencer;

    localparam int unsigned SAMPLE_DIV = 20;
    localparam int unsigned TIMEOUT    = 19;

    localparam int SEL_START   = 0;
    localparam int SEL_VALID   = 1;
    localparam int SEL_OVERRUN = 2;
    localparam int SEL_TIMEOUT = 3;

    logic        clk;
    logic        rst_n;
    logic        i_enable;
    logic [1:0]  i_ch_mask;
    logic        o_cnv_start;
    logic        o_cnv_odd;
    logic        i_cnv_busy;
    logic        i_cnv_done;
    logic [11:0] i_cnv_data;
    logic [11:0] o_ch0_data;
    logic [11:0] o_ch1_data;
    logic        o_data_valid;
    logic        o_data_ch;
    logic        o_overrun;
    logic        o_timeout;

    int          checkCount = 0;
    int          passCount  = 0;

    int          engLatency = 8;
    int          engCnt     = 0;
    logic        engPending = 1'b0;
    logic        forceBusy  = 1'b0;
    logic [11:0] engData    = 12'h000;

    adc_conversion_sequencer #(
        .SAMPLE_DIV(SAMPLE_DIV),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_enable    (i_enable),
        .i_ch_mask   (i_ch_mask),
        .o_cnv_start (o_cnv_start),
        .o_cnv_odd   (o_cnv_odd),
        .i_cnv_busy  (i_cnv_busy),
        .i_cnv_done  (i_cnv_done),
        .i_cnv_data  (i_cnv_data),
        .o_ch0_data  (o_ch0_data),
        .o_ch1_data  (o_ch1_data),
        .o_data_valid(o_data_valid),
        .o_data_ch   (o_data_ch),
        .o_overrun   (o_overrun),
        .o_timeout   (o_timeout)
    );

    // 8 ns clock
    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    // Engine busy while a conversion is pending, or when a step forces it
    assign i_cnv_busy = engPending | forceBusy;

    // Engine model: a start seen after a rising edge schedules done exactly
    // engLatency cycles later; reset abandons the pending conversion.
    initial begin
        i_cnv_done = 1'b0;
        i_cnv_data = 12'h000;
        forever begin
            @(posedge clk);
            #1;
            i_cnv_done = 1'b0;
            if (!rst_n) begin
                engPending = 1'b0;
            end else begin
                if (engPending) begin
                    engCnt = engCnt - 1;
                    if (engCnt == 0) begin
                        i_cnv_done = 1'b1;
                        i_cnv_data = engData;
                        engPending = 1'b0;
                    end
                end
                if (o_cnv_start && engLatency != 0) begin
                    engPending = 1'b1;
                    engCnt     = engLatency;
                end
            end
        end
    end

    // Global time limit
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic enable, input logic [1:0] mask);
        i_enable  = enable;
        i_ch_mask = mask;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Waits up to 'bound' falling edges for the selected output; n is the
    // number of edges waited (-1 if never seen). Also counts valid and
    // overrun pulses seen along the way.
    task automatic waitFor(input int sel, input int bound, output int n,
                           output int valids, output int overruns);
        logic hit;
        n        = -1;
        valids   = 0;
        overruns = 0;
        hit      = 1'b0;
        for (int k = 1; k <= bound && !hit; k++) begin
            @(negedge clk);
            valids   += int'(o_data_valid);
            overruns += int'(o_overrun);
            case (sel)
                SEL_START:   hit = o_cnv_start;
                SEL_VALID:   hit = o_data_valid;
                SEL_OVERRUN: hit = o_overrun;
                default:     hit = o_timeout;
            endcase
            if (hit) n = k;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_start"},   32'(o_cnv_start),  0);
        checkOutput({tag, "_odd"},     32'(o_cnv_odd),    0);
        checkOutput({tag, "_ch0"},     32'(o_ch0_data),   0);
        checkOutput({tag, "_ch1"},     32'(o_ch1_data),   0);
        checkOutput({tag, "_valid"},   32'(o_data_valid), 0);
        checkOutput({tag, "_datach"},  32'(o_data_ch),    0);
        checkOutput({tag, "_overrun"}, 32'(o_overrun),    0);
        checkOutput({tag, "_timeout"}, 32'(o_timeout),    0);
    endtask

    // Directed sequence
    initial begin
        int n;
        int v;
        int o;
        int ovrSum;
        logic [11:0] rrData [4];
        rrData[0] = 12'hA5C;
        rrData[1] = 12'h3F1;
        rrData[2] = 12'h123;
        rrData[3] = 12'h456;

        rst_n = 1'b0;
        applyStimulus(1'b0, 2'b00);
        repeat (3) @(negedge clk);
        checkAllZero("reset");

        // Round robin, mask=11: first start 21 cycles after enable, CH0 first
        $display("[TB] round robin with mask=11");
        rst_n   = 1'b1;
        engData = rrData[0];
        applyStimulus(1'b1, 2'b11);
        ovrSum = 0;
        for (int i = 0; i < 4; i++) begin
            engData = rrData[i];
            waitFor(SEL_START, 40, n, v, o);
            ovrSum += o;
            checkOutput($sformatf("rr%0d_start_lat", i), 32'(n), (i == 0) ? 21 : 11);
            checkOutput($sformatf("rr%0d_odd", i), 32'(o_cnv_odd), 32'(i % 2));
            waitFor(SEL_VALID, 20, n, v, o);
            ovrSum += o;
            checkOutput($sformatf("rr%0d_valid_lat", i), 32'(n), 9);
            checkOutput($sformatf("rr%0d_datach", i), 32'(o_data_ch), 32'(i % 2));
            if (i % 2 == 0) begin
                checkOutput($sformatf("rr%0d_ch0", i), 32'(o_ch0_data), 32'(rrData[i]));
            end else begin
                checkOutput($sformatf("rr%0d_ch1", i), 32'(o_ch1_data), 32'(rrData[i]));
            end
        end
        checkOutput("rr_ch0_final", 32'(o_ch0_data), 32'h123);
        checkOutput("rr_overruns", 32'(ovrSum), 0);

        // mask=10 with the engine busy past the tick: start waits for busy low
        $display("[TB] mask=10 with busy stall");
        applyStimulus(1'b1, 2'b10);
        engData   = 12'h5AA;
        forceBusy = 1'b1;
        waitFor(SEL_START, 13, n, v, o);
        checkOutput("busy_no_start", 32'(n), 32'hFFFF_FFFF);
        forceBusy = 1'b0;
        waitFor(SEL_START, 5, n, v, o);
        checkOutput("busy_release_lat", 32'(n), 1);
        checkOutput("m10_odd_a", 32'(o_cnv_odd), 1);
        waitFor(SEL_VALID, 20, n, v, o);
        checkOutput("m10_ch1_a", 32'(o_ch1_data), 32'h5AA);
        engData = 12'h6BB;
        waitFor(SEL_START, 30, n, v, o);
        checkOutput("m10_start_lat_b", 32'(n), 8);
        checkOutput("m10_odd_b", 32'(o_cnv_odd), 1);
        waitFor(SEL_VALID, 20, n, v, o);
        checkOutput("m10_ch1_b", 32'(o_ch1_data), 32'h6BB);
        checkOutput("m10_ch0_kept", 32'(o_ch0_data), 32'h123);

        // mask=00: five ticks pass with no start and no overrun
        $display("[TB] mask=00 idle ticks");
        applyStimulus(1'b1, 2'b00);
        waitFor(SEL_START, 105, n, v, o);
        checkOutput("m00_no_start", 32'(n), 32'hFFFF_FFFF);
        checkOutput("m00_no_overrun", 32'(o), 0);

        // Slow engine (latency 25): tick during WAIT_DONE is an overrun, the
        // wait then times out and the next start comes one tick later on CH1
        $display("[TB] slow engine overrun");
        engLatency = 25;
        applyStimulus(1'b1, 2'b11);
        waitFor(SEL_START, 30, n, v, o);
        checkOutput("ovr_start_lat", 32'(n), 6);
        checkOutput("ovr_odd", 32'(o_cnv_odd), 0);
        waitFor(SEL_OVERRUN, 30, n, v, o);
        checkOutput("ovr_overrun_lat", 32'(n), 19);
        checkOutput("ovr_timeout_same", 32'(o_timeout), 1);
        checkOutput("ovr_no_valid", 32'(v), 0);
        engLatency = 0;
        waitFor(SEL_START, 30, n, v, o);
        checkOutput("ovr_next_start_lat", 32'(n), 21);
        checkOutput("ovr_next_odd", 32'(o_cnv_odd), 1);
        checkOutput("ovr_late_done_ignored", 32'(v), 0);

        // Hung engine: timeout 19 cycles into WAIT_DONE, then the other channel
        $display("[TB] hung engine timeout");
        waitFor(SEL_TIMEOUT, 30, n, v, o);
        checkOutput("to_lat", 32'(n), 19);
        checkOutput("to_no_valid", 32'(v), 0);
        engLatency = 8;
        engData    = 12'h7E2;
        waitFor(SEL_START, 30, n, v, o);
        checkOutput("to_next_start_lat", 32'(n), 21);
        checkOutput("to_next_odd", 32'(o_cnv_odd), 0);

        // Enable drops 3 cycles after start: result still captured, then idle
        $display("[TB] enable drop during conversion");
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 2'b11);
        waitFor(SEL_VALID, 20, n, v, o);
        checkOutput("dis_valid_lat", 32'(n), 6);
        checkOutput("dis_ch0", 32'(o_ch0_data), 32'h7E2);
        checkOutput("dis_datach", 32'(o_data_ch), 0);
        waitFor(SEL_START, 65, n, v, o);
        checkOutput("dis_no_start", 32'(n), 32'hFFFF_FFFF);
        checkOutput("dis_no_overrun", 32'(o), 0);

        // Re-enable, then reset in the middle of WAIT_DONE
        $display("[TB] reset during conversion");
        engLatency = 0;
        applyStimulus(1'b1, 2'b11);
        waitFor(SEL_START, 40, n, v, o);
        checkOutput("re_start_lat", 32'(n), 21);
        checkOutput("re_odd", 32'(o_cnv_odd), 1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkAllZero("midrst");
        rst_n = 1'b1;
        waitFor(SEL_START, 40, n, v, o);
        checkOutput("post_rst_start_lat", 32'(n), 21);
        checkOutput("post_rst_odd", 32'(o_cnv_odd), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
